control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  - Fetch/decode/execute sequencer that sits directly upstream of the datapath and drives every datapath control input.
//  - Fetches 16-bit instructions from a synchronous instruction ROM, holds them in IR and advances PC.
//  - Drives D_addr, D_wr, RF_s, RF_W_en, the RF addresses and ALU_sel, one multi-cycle instruction at a time.
// PARAMETERS
//  I_ADDR_W  7  instruction ROM address width; PC width
//  D_ADDR_W  8  data memory address width; must be 8 to match the instruction fields
//  R_ADDR_W  4  register file address width; must be 4 to match the instruction fields
// PORTS
//  clk        in   1         rising-edge clock; the only clock
//  rst_n      in   1         asynchronous active-low reset
//  run        in   1         start request, sampled only in INIT
//  i_data     in   16        ROM read data, valid the cycle after i_addr is registered
//  i_addr     out  I_ADDR_W  ROM address (= PC)
//  D_addr     out  D_ADDR_W  data memory address
//  D_wr       out  1         data memory write enable
//  RF_s       out  1         RF write source: 0 = memory, 1 = ALU
//  RF_W_en    out  1         RF write enable
//  RF_W_addr  out  R_ADDR_W  RF write address
//  RF_A_addr  out  R_ADDR_W  RF read address A
//  RF_B_addr  out  R_ADDR_W  RF read address B
//  ALU_sel    out  4         ALU opcode
//  halted     out  1         high in HALT
//  state_o    out  4         current state, for debug and the bench
//  ir_o       out  16        instruction register
// BEHAVIOUR
//  - Opcodes (ir[15:12]):
//    - NOOP 0
//    - STORE 1: RF[ir[11:8]] -> M[ir[7:0]]
//    - LOAD 2: M[ir[11:4]] -> RF[ir[3:0]]
//    - ADD 3: RF[ir[3:0]] = RF[ir[11:8]] + RF[ir[7:4]]
//    - SUB 4: RF[ir[3:0]] = RF[ir[11:8]] - RF[ir[7:4]]
//    - HALT 5
//    - 6..F illegal
//  - Reset (async, any state): state=INIT, PC=0, IR=0, all enables 0, all addresses 0, ALU_sel=`A_ZERO, halted=0.
//    - Reset in mid-instruction aborts it; no write enable may stay high past the rst_n assertion.
//  - State sequence:
//    - INIT: wait; run=1 -> FETCH.
//    - FETCH: ROM registers i_addr=PC at the end of this cycle -> DECODE.
//    - DECODE: IR<=i_data, PC<=PC+1 (wraps 2^I_ADDR_W-1 -> 0); next state by i_data[15:12].
//    - NOOP -> FETCH.
//    - LOAD_A: D_addr=ir[11:4] -> LOAD_B.
//    - LOAD_B: D_addr held, RF_s=0, RF_W_en=1, RF_W_addr=ir[3:0] -> FETCH.
//    - STORE: RF_A_addr=ir[11:8], D_addr=ir[7:0], D_wr=1 -> FETCH.
//    - ALU: RF_A_addr=ir[11:8], RF_B_addr=ir[7:4], RF_W_addr=ir[3:0], ALU_sel=`A_ADD or `A_SUB, RF_s=1, RF_W_en=1 -> FETCH.
//    - HALT: halted=1; stays until reset; run ignored.
//  - Control outputs are decoded from state and IR only; no combinational path from i_data or run to any output.
//  - Enables (D_wr, RF_W_en) are 1 in exactly one cycle per STORE/LOAD/ALU instruction and 0 in every other state.
//  - Instruction latencies: NOOP 2 cycles, STORE 3, ALU 3, LOAD 4, counted FETCH to FETCH.
//  - Arithmetic: PC is unsigned modulo 2^I_ADDR_W; ADD/SUB wrap-around is the ALU's concern.
//  - Illegal opcode: treated as NOOP (-> FETCH).
// CONFIGURATION
//  - CU_ILLEGAL_HALT_EN defined:
//    - Illegal opcode -> HALT; halted=1; extra output illegal_o=1 held until reset.
//    - PC stays pointing past the bad word.
//  - CU_ILLEGAL_HALT_EN undefined: illegal opcode = NOOP; the illegal_o port does not exist.
// STRUCTURE
//  - Package cu_pkg holds:
//    - the opcode_t enum (NOOP..HALT),
//    - the state_t enum (INIT, FETCH, DECODE, LOAD_A, LOAD_B, STORE, ALU, HALT; 4-bit encoding),
//    - the instruction field slice localparams.
//  - ALU_sel codes come from instructions.vh.
//  - One sub-module, pc_reg: loadable, clearable I_ADDR_W counter with an increment enable.
//    - The FSM and the IR stay in control_unit.
// TESTING
//  - Reset:
//    - Drop rst_n mid-LOAD_B -> all enables 0 immediately, state_o=INIT, i_addr=0.
//    - With run=0 the block stays in INIT for 10 cycles.
//  - LOAD:
//    - ROM[0]=16'h2A53 -> D_addr=8'hA5 in LOAD_A and LOAD_B.
//    - In LOAD_B: RF_W_en=1, RF_s=0, RF_W_addr=3.
//    - Next FETCH presents i_addr=1.
//  - STORE:
//    - 16'h1742 -> exactly one cycle with D_wr=1, RF_A_addr=7, D_addr=8'h42.
//    - RF_W_en=0 throughout.
//  - ADD/SUB:
//    - 16'h3125 -> A=1, B=2, W=5, ALU_sel=`A_ADD, RF_s=1, RF_W_en=1 for one cycle.
//    - 16'h4125 -> same fields with `A_SUB.
//  - HALT and wrap:
//    - 16'h5000 -> halted=1; run toggled for 20 cycles -> no change.
//    - NOOPs fill the ROM from PC=127 -> PC wraps to 0.
//  - Illegal opcode:
//    - 16'hF000 without the macro -> behaves as NOOP.
//    - With CU_ILLEGAL_HALT_EN -> halted=1 and illegal_o=1.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared types for the control unit: opcodes, FSM states, instruction field slices
// and the bundle of registered datapath controls.
`include "instructions.vh"

package cu_pkg;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'd0,
    OP_STORE = 4'd1,
    OP_LOAD  = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_HALT  = 4'd5
  } opcode_t;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD_A = 4'd3,
    S_LOAD_B = 4'd4,
    S_STORE  = 4'd5,
    S_ALU    = 4'd6,
    S_HALT   = 4'd7
  } state_t;

  // Instruction field slices (ir[HI:LO])
  localparam int F_OP_HI    = 15;
  localparam int F_OP_LO    = 12;
  localparam int F_RA_HI    = 11;
  localparam int F_RA_LO    = 8;
  localparam int F_RB_HI    = 7;
  localparam int F_RB_LO    = 4;
  localparam int F_RW_HI    = 3;
  localparam int F_RW_LO    = 0;
  localparam int F_LADDR_HI = 11;
  localparam int F_LADDR_LO = 4;
  localparam int F_SADDR_HI = 7;
  localparam int F_SADDR_LO = 0;

  typedef struct packed {
    logic [7:0] d_addr;
    logic       d_wr;
    logic       rf_s;
    logic       rf_w_en;
    logic [3:0] w_addr;
    logic [3:0] a_addr;
    logic [3:0] b_addr;
    logic [3:0] alu_sel;
    logic       halted;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    d_addr:  8'h00,
    d_wr:    1'b0,
    rf_s:    1'b0,
    rf_w_en: 1'b0,
    w_addr:  4'h0,
    a_addr:  4'h0,
    b_addr:  4'h0,
    alu_sel: `A_ZERO,
    halted:  1'b0
  };

endpackage

// File: rtl/control_unit_pc_reg.sv
// Program counter: clearable, loadable W-bit register with a wrapping increment.
module pc_reg #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  // Counter register; clear beats load beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= {W{1'b0}};
    end else if (clr) begin
      q_r <= {W{1'b0}};
    end else if (ld) begin
      q_r <= ld_val;
    end else if (inc) begin
      q_r <= q_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/instructions.vh
// ALU opcode codes driven on ALU_sel, shared by the control unit and the datapath.
`ifndef INSTRUCTIONS_VH
`define INSTRUCTIONS_VH
`define A_ZERO 4'h0
`define A_ADD  4'h1
`define A_SUB  4'h2
`endif

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer driving the datapath controls from state and IR.
// Optional CU_ILLEGAL_HALT_EN: illegal opcodes halt and raise illegal_o.
`include "instructions.vh"

module control_unit
  import cu_pkg::*;
#(
  parameter int I_ADDR_W = 7,
  parameter int D_ADDR_W = 8,
  parameter int R_ADDR_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [15:0]         i_data,
  output logic [I_ADDR_W-1:0] i_addr,
  output logic [D_ADDR_W-1:0] D_addr,
  output logic                D_wr,
  output logic                RF_s,
  output logic                RF_W_en,
  output logic [R_ADDR_W-1:0] RF_W_addr,
  output logic [R_ADDR_W-1:0] RF_A_addr,
  output logic [R_ADDR_W-1:0] RF_B_addr,
  output logic [3:0]          ALU_sel,
  output logic                halted,
  output logic [3:0]          state_o,
  output logic [15:0]         ir_o
`ifdef CU_ILLEGAL_HALT_EN
  ,output logic               illegal_o
`endif
);

  state_t        state_r, state_next_s;
  logic [15:0]   ir_r, ir_next_s;
  ctrl_t         ctrl_r;
  logic          pc_inc_s;
  logic          pc_clr_s;
  logic [I_ADDR_W-1:0] pc_s;
`ifdef CU_ILLEGAL_HALT_EN
  logic          illegal_r, illegal_set_s;
`endif

  // Datapath controls asserted while sitting in state s with instruction ir.
  function automatic ctrl_t ctrl_decode(input state_t s, input logic [15:0] ir);
    ctrl_t c;
    c = CTRL_IDLE;
    case (s)
      S_LOAD_A: begin
        c.d_addr = ir[F_LADDR_HI:F_LADDR_LO];
      end
      S_LOAD_B: begin
        c.d_addr  = ir[F_LADDR_HI:F_LADDR_LO];
        c.rf_s    = 1'b0;
        c.rf_w_en = 1'b1;
        c.w_addr  = ir[F_RW_HI:F_RW_LO];
      end
      S_STORE: begin
        c.a_addr = ir[F_RA_HI:F_RA_LO];
        c.d_addr = ir[F_SADDR_HI:F_SADDR_LO];
        c.d_wr   = 1'b1;
      end
      S_ALU: begin
        c.a_addr  = ir[F_RA_HI:F_RA_LO];
        c.b_addr  = ir[F_RB_HI:F_RB_LO];
        c.w_addr  = ir[F_RW_HI:F_RW_LO];
        c.alu_sel = (ir[F_OP_HI:F_OP_LO] == OP_SUB) ? `A_SUB : `A_ADD;
        c.rf_s    = 1'b1;
        c.rf_w_en = 1'b1;
      end
      S_HALT: begin
        c.halted = 1'b1;
      end
      default: begin
        c = CTRL_IDLE;
      end
    endcase
    return c;
  endfunction

  assign pc_clr_s = (state_r == S_INIT);

  pc_reg #(.W(I_ADDR_W)) u_pc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (pc_clr_s),
    .ld     (1'b0),
    .ld_val ({I_ADDR_W{1'b0}}),
    .inc    (pc_inc_s),
    .q      (pc_s)
  );

  // Next-state, IR capture and PC advance.
  always_comb begin
    state_next_s = state_r;
    ir_next_s    = ir_r;
    pc_inc_s     = 1'b0;
`ifdef CU_ILLEGAL_HALT_EN
    illegal_set_s = 1'b0;
`endif
    case (state_r)
      S_INIT: begin
        if (run) begin
          state_next_s = S_FETCH;
        end else begin
          state_next_s = S_INIT;
        end
      end
      S_FETCH:  state_next_s = S_DECODE;
      S_DECODE: begin
        ir_next_s = i_data;
        pc_inc_s  = 1'b1;
        case (i_data[F_OP_HI:F_OP_LO])
          OP_NOOP:  state_next_s = S_FETCH;
          OP_STORE: state_next_s = S_STORE;
          OP_LOAD:  state_next_s = S_LOAD_A;
          OP_ADD:   state_next_s = S_ALU;
          OP_SUB:   state_next_s = S_ALU;
          OP_HALT:  state_next_s = S_HALT;
          default: begin
`ifdef CU_ILLEGAL_HALT_EN
            state_next_s  = S_HALT;
            illegal_set_s = 1'b1;
`else
            state_next_s = S_FETCH;
`endif
          end
        endcase
      end
      S_LOAD_A: state_next_s = S_LOAD_B;
      S_LOAD_B: state_next_s = S_FETCH;
      S_STORE:  state_next_s = S_FETCH;
      S_ALU:    state_next_s = S_FETCH;
      S_HALT:   state_next_s = S_HALT;
      default:  state_next_s = S_INIT;
    endcase
  end

  // State, IR and output registers; controls are precomputed for the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_INIT;
      ir_r    <= 16'h0000;
      ctrl_r  <= CTRL_IDLE;
    end else begin
      state_r <= state_next_s;
      ir_r    <= ir_next_s;
      ctrl_r  <= ctrl_decode(state_next_s, ir_next_s);
    end
  end

`ifdef CU_ILLEGAL_HALT_EN
  // Sticky illegal-opcode flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_r <= 1'b0;
    end else if (illegal_set_s) begin
      illegal_r <= 1'b1;
    end else begin
      illegal_r <= illegal_r;
    end
  end

  assign illegal_o = illegal_r;
`endif

  assign i_addr    = pc_s;
  assign D_addr    = ctrl_r.d_addr;
  assign D_wr      = ctrl_r.d_wr;
  assign RF_s      = ctrl_r.rf_s;
  assign RF_W_en   = ctrl_r.rf_w_en;
  assign RF_W_addr = ctrl_r.w_addr;
  assign RF_A_addr = ctrl_r.a_addr;
  assign RF_B_addr = ctrl_r.b_addr;
  assign ALU_sel   = ctrl_r.alu_sel;
  assign halted    = ctrl_r.halted;
  assign state_o   = state_r;
  assign ir_o      = ir_r;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit with a synchronous instruction ROM model.
module tb_control_unit;

  localparam logic [3:0] ST_INIT = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2,
                         ST_LOAD_A = 4'd3, ST_LOAD_B = 4'd4, ST_STORE = 4'd5,
                         ST_ALU = 4'd6, ST_HALT = 4'd7;
  localparam logic [3:0] SEL_ZERO = 4'h0, SEL_ADD = 4'h1, SEL_SUB = 4'h2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [15:0] i_data = 16'h0000;
  logic [6:0]  i_addr;
  logic [7:0]  D_addr;
  logic        D_wr, RF_s, RF_W_en, halted;
  logic [3:0]  RF_W_addr, RF_A_addr, RF_B_addr, ALU_sel, state_o;
  logic [15:0] ir_o;
`ifdef CU_ILLEGAL_HALT_EN
  logic        illegal_o;
`endif

  logic [15:0] rom [128];
  int checks = 0;
  int errors = 0;

  control_unit dut (
    .clk(clk), .rst_n(rst_n), .run(run), .i_data(i_data), .i_addr(i_addr),
    .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s), .RF_W_en(RF_W_en),
    .RF_W_addr(RF_W_addr), .RF_A_addr(RF_A_addr), .RF_B_addr(RF_B_addr),
    .ALU_sel(ALU_sel), .halted(halted), .state_o(state_o), .ir_o(ir_o)
`ifdef CU_ILLEGAL_HALT_EN
    , .illegal_o(illegal_o)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) i_data <= rom[i_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctrl(input string tag, input logic [3:0] st, input logic [7:0] da,
                          input logic dwr, input logic rfs, input logic wen,
                          input logic [3:0] wa, input logic [3:0] aa, input logic [3:0] ba,
                          input logic [3:0] sel, input logic hlt);
    chk({tag, ".state"},  {28'h0, state_o},   {28'h0, st});
    chk({tag, ".D_addr"}, {24'h0, D_addr},    {24'h0, da});
    chk({tag, ".D_wr"},   {31'h0, D_wr},      {31'h0, dwr});
    chk({tag, ".RF_s"},   {31'h0, RF_s},      {31'h0, rfs});
    chk({tag, ".RF_W_en"},{31'h0, RF_W_en},   {31'h0, wen});
    chk({tag, ".W_addr"}, {28'h0, RF_W_addr}, {28'h0, wa});
    chk({tag, ".A_addr"}, {28'h0, RF_A_addr}, {28'h0, aa});
    chk({tag, ".B_addr"}, {28'h0, RF_B_addr}, {28'h0, ba});
    chk({tag, ".ALU_sel"},{28'h0, ALU_sel},   {28'h0, sel});
    chk({tag, ".halted"}, {31'h0, halted},    {31'h0, hlt});
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  initial begin
    logic found;
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    rom[0] = 16'h2A53;
    rom[1] = 16'h1742;
    rom[2] = 16'h3125;
    rom[3] = 16'h4125;
    rom[4] = 16'hF000;
    rom[5] = 16'h0000;
    rom[6] = 16'h5000;

    repeat (2) step();
    rst_n = 1'b1;
    chk_ctrl("reset", ST_INIT, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, SEL_ZERO, 1'b0);
    chk("reset.i_addr", {25'h0, i_addr}, 32'h0);
    chk("reset.ir", {16'h0, ir_o}, 32'h0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle.state", {28'h0, state_o}, {28'h0, ST_INIT});
    end

    // LOAD 2A53
    run = 1'b1;
    step();
    chk("ld.fetch.state", {28'h0, state_o}, {28'h0, ST_FETCH});
    chk("ld.fetch.i_addr", {25'h0, i_addr}, 32'h0);
    step();
    chk_ctrl("ld.decode", ST_DECODE, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, SEL_ZERO, 1'b0);
    step();
    chk_ctrl("ld.a", ST_LOAD_A, 8'hA5, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, SEL_ZERO, 1'b0);
    chk("ld.a.ir", {16'h0, ir_o}, 32'h2A53);
    chk("ld.a.i_addr", {25'h0, i_addr}, 32'h1);
    step();
    chk_ctrl("ld.b", ST_LOAD_B, 8'hA5, 1'b0, 1'b0, 1'b1, 4'h3, 4'h0, 4'h0, SEL_ZERO, 1'b0);
    step();
    chk_ctrl("ld.next", ST_FETCH, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, SEL_ZERO, 1'b0);
    chk("ld.next.i_addr", {25'h0, i_addr}, 32'h1);

    // STORE 1742
    step();
    chk_ctrl("st.decode", ST_DECODE, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, SEL_ZERO, 1'b0);
    step();
    chk_ctrl("st.exec", ST_STORE, 8'h42, 1'b1, 1'b0, 1'b0, 4'h0, 4'h7, 4'h0, SEL_ZERO, 1'b0);
    step();
    chk_ctrl("st.next", ST_FETCH, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, SEL_ZERO, 1'b0);
    chk("st.next.i_addr", {25'h0, i_addr}, 32'h2);

    // ADD 3125
    step();
    step();
    chk_ctrl("add.exec", ST_ALU, 8'h00, 1'b0, 1'b1, 1'b1, 4'h5, 4'h1, 4'h2, SEL_ADD, 1'b0);
    step();
    chk_ctrl("add.next", ST_FETCH, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, SEL_ZERO, 1'b0);

    // SUB 4125
    step();
    step();
    chk_ctrl("sub.exec", ST_ALU, 8'h00, 1'b0, 1'b1, 1'b1, 4'h5, 4'h1, 4'h2, SEL_SUB, 1'b0);
    step();
    chk("sub.next.i_addr", {25'h0, i_addr}, 32'h4);

    // Illegal F000
    step();
    step();
`ifdef CU_ILLEGAL_HALT_EN
    chk_ctrl("ill.halt", ST_HALT, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, SEL_ZERO, 1'b1);
    chk("ill.illegal_o", {31'h0, illegal_o}, 32'h1);
    chk("ill.i_addr", {25'h0, i_addr}, 32'h5);
`else
    chk_ctrl("ill.noop", ST_FETCH, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, SEL_ZERO, 1'b0);
    chk("ill.ir", {16'h0, ir_o}, 32'hF000);
    chk("ill.i_addr", {25'h0, i_addr}, 32'h5);
    step();
    step();
    chk("noop.i_addr", {25'h0, i_addr}, 32'h6);
    step();
    step();
    chk_ctrl("halt", ST_HALT, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, SEL_ZERO, 1'b1);
    chk("halt.i_addr", {25'h0, i_addr}, 32'h7);
`endif
    for (int i = 0; i < 20; i++) begin
      run = ~run;
      step();
      chk("halt.hold.state", {28'h0, state_o}, {28'h0, ST_HALT});
      chk("halt.hold.halted", {31'h0, halted}, 32'h1);
    end

    // Reset out of HALT, then abort a LOAD in LOAD_B
    rst_n = 1'b0;
    #1;
    chk_ctrl("rst.halt", ST_INIT, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, SEL_ZERO, 1'b0);
    step();
    rst_n = 1'b1;
    run = 1'b1;
    repeat (4) step();
    chk("abort.pre.wen", {31'h0, RF_W_en}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk_ctrl("abort", ST_INIT, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, SEL_ZERO, 1'b0);
    chk("abort.i_addr", {25'h0, i_addr}, 32'h0);

    // All-NOOP ROM: PC wraps from 127 to 0
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    step();
    rst_n = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      step();
      if (state_o == ST_FETCH && i_addr == 7'd127) found = 1'b1;
    end
    chk("wrap.reach127", {31'h0, found}, 32'h1);
    step();
    chk("wrap.decode.state", {28'h0, state_o}, {28'h0, ST_DECODE});
    step();
    chk("wrap.fetch.state", {28'h0, state_o}, {28'h0, ST_FETCH});
    chk("wrap.i_addr", {25'h0, i_addr}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
